// File: rtl/array_multiplier_if.sv
// Operand and result bundle for the 3x3 systolic array_multiplier tile.
// The master drives the six edge operands; the slave returns the nine accumulators.
interface array_multiplier_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 64
);
    logic [DATA_W-1:0] a, b, c, d, e, f;
    logic [ACC_W-1:0]  out1, out2, out3, out4, out5, out6, out7, out8, out9;

    modport master (
        output a, b, c, d, e, f,
        input  out1, out2, out3, out4, out5, out6, out7, out8, out9
    );

    modport slave (
        input  a, b, c, d, e, f,
        output out1, out2, out3, out4, out5, out6, out7, out8, out9
    );
endinterface

// File: rtl/array_multiplier.sv
// 3x3 output-stationary systolic array computing C = A x B with internal input skew.
// Define ARRAY_MULT_SIGNED_EN for two's-complement operands; default is unsigned.
module array_multiplier #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 64
) (
    input logic              clk,
    input logic              rst,
    array_multiplier_if.slave bus
);

    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] c_q [2];
    logic [DATA_W-1:0] e_q;
    logic [DATA_W-1:0] f_q [2];

    logic [DATA_W-1:0] row_in [3];
    logic [DATA_W-1:0] col_in [3];

    // Only the pass-through registers that feed a neighbour exist.
    logic [DATA_W-1:0] right_q [3][2];
    logic [DATA_W-1:0] down_q  [2][3];

    logic [DATA_W-1:0] left_in [3][3];
    logic [DATA_W-1:0] top_in  [3][3];

    logic [ACC_W-1:0] acc_q [3][3];
    logic [ACC_W-1:0] acc_d [3][3];

    function automatic logic [ACC_W-1:0] mul(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y);
        logic [ACC_W-1:0] xe;
        logic [ACC_W-1:0] ye;
`ifdef ARRAY_MULT_SIGNED_EN
        xe = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
        ye = {{(ACC_W-DATA_W){y[DATA_W-1]}}, y};
`else
        xe = {{(ACC_W-DATA_W){1'b0}}, x};
        ye = {{(ACC_W-DATA_W){1'b0}}, y};
`endif
        // Low ACC_W bits of the product are identical for signed and unsigned.
        return xe * ye;
    endfunction

    always_comb begin
        row_in[0] = bus.a;
        row_in[1] = b_q;
        row_in[2] = c_q[1];
        col_in[0] = bus.d;
        col_in[1] = e_q;
        col_in[2] = f_q[1];
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            left_in[i][0] = row_in[i];
            top_in[0][i]  = col_in[i];
            for (int j = 1; j < 3; j++) begin
                left_in[i][j] = right_q[i][j-1];
                top_in[j][i]  = down_q[j-1][i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc_d[i][j] = acc_q[i][j] + mul(left_in[i][j], top_in[i][j]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_q <= '0;
            e_q <= '0;
            for (int k = 0; k < 2; k++) begin
                c_q[k] <= '0;
                f_q[k] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 2; j++) begin
                    right_q[i][j] <= '0;
                    down_q[j][i]  <= '0;
                end
                for (int j = 0; j < 3; j++) begin
                    acc_q[i][j] <= '0;
                end
            end
        end else begin
            b_q    <= bus.b;
            c_q[0] <= bus.c;
            c_q[1] <= c_q[0];
            e_q    <= bus.e;
            f_q[0] <= bus.f;
            f_q[1] <= f_q[0];
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 2; j++) begin
                    right_q[i][j] <= left_in[i][j];
                    down_q[j][i]  <= top_in[j][i];
                end
                for (int j = 0; j < 3; j++) begin
                    acc_q[i][j] <= acc_d[i][j];
                end
            end
        end
    end

    assign bus.out1 = acc_q[0][0];
    assign bus.out2 = acc_q[0][1];
    assign bus.out3 = acc_q[0][2];
    assign bus.out4 = acc_q[1][0];
    assign bus.out5 = acc_q[1][1];
    assign bus.out6 = acc_q[1][2];
    assign bus.out7 = acc_q[2][0];
    assign bus.out8 = acc_q[2][1];
    assign bus.out9 = acc_q[2][2];

endmodule

// File: tb/tb_array_multiplier.sv
// Directed, table-driven bench for array_multiplier: reset, full multiplies,
// per-PE latency, mid-operation reset and 64-bit wrap.
module tb_array_multiplier;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    array_multiplier_if #(.DATA_W(32), .ACC_W(64)) bus ();

    array_multiplier #(.DATA_W(32), .ACC_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] outs [9];
    always_comb begin
        outs[0] = bus.out1;
        outs[1] = bus.out2;
        outs[2] = bus.out3;
        outs[3] = bus.out4;
        outs[4] = bus.out5;
        outs[5] = bus.out6;
        outs[6] = bus.out7;
        outs[7] = bus.out8;
        outs[8] = bus.out9;
    end

    // lhs[k] = {a,b,c} and rhs[k] = {d,e,f} for step k.
    typedef struct {
        string       name;
        logic [31:0] lhs [3][3];
        logic [31:0] rhs [3][3];
        logic [63:0] exp [9];
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int idx, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s out%0d: got 0x%016h, expected 0x%016h", name, idx + 1, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv,
                         input logic [31:0] dv, input logic [31:0] ev, input logic [31:0] fv);
        bus.a = av;
        bus.b = bv;
        bus.c = cv;
        bus.d = dv;
        bus.e = ev;
        bus.f = fv;
    endtask

    task automatic step(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv,
                        input logic [31:0] dv, input logic [31:0] ev, input logic [31:0] fv);
        drive(av, bv, cv, dv, ev, fv);
        @(posedge clk);
        #1;
    endtask

    // Release lands on a falling edge, so the next rising edge is edge 0.
    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_vec(input int n);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(vecs[n].lhs[k][0], vecs[n].lhs[k][1], vecs[n].lhs[k][2],
                 vecs[n].rhs[k][0], vecs[n].rhs[k][1], vecs[n].rhs[k][2]);
        end
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 0);
        for (int o = 0; o < 9; o++) check(vecs[n].name, o, outs[o], vecs[n].exp[o]);
        // Results must hold while zeros keep flowing.
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);
        for (int o = 0; o < 9; o++) check({vecs[n].name, "_hold"}, o, outs[o], vecs[n].exp[o]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;

        vecs[0].name = "nominal";
        vecs[0].lhs  = '{'{32'd4, 32'd5, 32'd2}, '{32'd6, 32'd7, 32'd6}, '{32'd7, 32'd5, 32'd3}};
        vecs[0].rhs  = '{'{32'd3, 32'd6, 32'd3}, '{32'd2, 32'd4, 32'd5}, '{32'd4, 32'd5, 32'd6}};
        vecs[0].exp  = '{64'd52, 64'd83, 64'd84, 64'd49, 64'd83, 64'd80, 64'd30, 64'd51, 64'd54};

        vecs[1].name = "identity";
        vecs[1].lhs  = '{'{32'd1, 32'd0, 32'd0}, '{32'd0, 32'd1, 32'd0}, '{32'd0, 32'd0, 32'd1}};
        vecs[1].rhs  = '{'{32'd1, 32'd2, 32'd3}, '{32'd4, 32'd5, 32'd6}, '{32'd7, 32'd8, 32'd9}};
        vecs[1].exp  = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8, 64'd9};

        vecs[2].name = "uniform";
        vecs[2].lhs  = '{'{32'd2, 32'd2, 32'd2}, '{32'd2, 32'd2, 32'd2}, '{32'd2, 32'd2, 32'd2}};
        vecs[2].rhs  = '{'{32'd3, 32'd3, 32'd3}, '{32'd3, 32'd3, 32'd3}, '{32'd3, 32'd3, 32'd3}};
        vecs[2].exp  = '{64'd18, 64'd18, 64'd18, 64'd18, 64'd18, 64'd18, 64'd18, 64'd18, 64'd18};

        vecs[3].name = "wrap2";
        vecs[3].lhs  = '{'{32'hFFFFFFFF, 32'd0, 32'd0}, '{32'hFFFFFFFF, 32'd0, 32'd0},
                         '{32'd0, 32'd0, 32'd0}};
        vecs[3].rhs  = '{'{32'hFFFFFFFF, 32'd0, 32'd0}, '{32'hFFFFFFFF, 32'd0, 32'd0},
                         '{32'd0, 32'd0, 32'd0}};
`ifdef ARRAY_MULT_SIGNED_EN
        vecs[3].exp  = '{64'd2, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
`else
        vecs[3].exp  = '{64'hFFFFFFFC00000002, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                         64'd0};
`endif

        vecs[4].name = "sign";
        vecs[4].lhs  = '{'{32'hFFFFFFFF, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0},
                         '{32'd0, 32'd0, 32'd0}};
        vecs[4].rhs  = '{'{32'd3, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0}};
`ifdef ARRAY_MULT_SIGNED_EN
        vecs[4].exp  = '{64'hFFFFFFFFFFFFFFFD, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                         64'd0};
`else
        vecs[4].exp  = '{64'h00000002FFFFFFFD, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                         64'd0};
`endif

        // Reset held with live inputs and a running clock keeps every output at zero.
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 4; n++) begin
            drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            @(posedge clk);
            #1;
            for (int o = 0; o < 9; o++) check("reset_hold", o, outs[o], 64'd0);
        end

        for (int n = 0; n < 5; n++) run_vec(n);

        // Single square of 0xFFFFFFFF.
        do_reset();
        step(32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 0, 0);
`ifdef ARRAY_MULT_SIGNED_EN
        check("wrap1", 0, outs[0], 64'd1);
`else
        check("wrap1", 0, outs[0], 64'hFFFFFFFE00000001);
`endif

        // Latency: PE(i,j) sees the single all-ones step at edge i+j.
        do_reset();
        step(1, 1, 1, 1, 1, 1);
        for (int n = 0; n < 7; n++) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    check($sformatf("latency_e%0d", n), i * 3 + j, outs[i * 3 + j],
                          (n >= i + j) ? 64'd1 : 64'd0);
                end
            end
            step(0, 0, 0, 0, 0, 0);
        end

        // Mid-operation asynchronous reset between edges, then a clean rerun.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(vecs[0].lhs[k][0], vecs[0].lhs[k][1], vecs[0].lhs[k][2],
                 vecs[0].rhs[k][0], vecs[0].rhs[k][1], vecs[0].rhs[k][2]);
        end
        check("midrst_partial", 0, outs[0], 64'd52);
        #2;
        rst = 1'b0;
        #1;
        for (int o = 0; o < 9; o++) check("midrst_async", o, outs[o], 64'd0);
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
